// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the serial adder: latches two operands and a
// carry-in on a valid/ready accept, then presents them LSB-first, one bit per clock.
//
// state | meaning
// IDLE  | no frame in flight, ready for operands
// SHIFT | presenting operand bits 0..WIDTH-1
// GAPS  | idle spacing cycles after a frame (GAP > 0 only)
module serial_operand_feeder #(
  parameter int WIDTH = 4,
  parameter int GAP = 0,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             a,
  output logic             b,
  output logic             carryin,
  output logic             bit_valid,
  output logic [CW-1:0]    bit_idx,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state, state_n;
  logic [CW-1:0]    idx_n;
  logic [3:0]       gap_cnt, gap_n;
  logic [WIDTH-1:0] sh_a, sh_b, sh_a_n, sh_b_n;
  logic             last_bit, last_gap, accept;

  assign last_bit = (state == SHIFT) && (bit_idx == LAST_IDX);
  assign last_gap = (state == GAPS) && (gap_cnt == 4'd0);
  assign in_ready = rst_n && !flush &&
                    ((state == IDLE) || (last_bit && (GAP == 0)) || last_gap);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    idx_n   = '0;
    gap_n   = gap_cnt;
    sh_a_n  = sh_a;
    sh_b_n  = sh_b;
    unique case (state)
      IDLE:  state_n = IDLE;
      SHIFT: begin
        if (!last_bit) begin
          idx_n  = bit_idx + 1'b1;
          sh_a_n = sh_a >> 1;
          sh_b_n = sh_b >> 1;
        end else if (GAP == 0) begin
          state_n = IDLE;
        end else begin
          state_n = GAPS;
          gap_n   = GAP_LOAD;
        end
      end
      GAPS: begin
        if (last_gap) state_n = IDLE;
        else          gap_n   = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      state_n = SHIFT;
      idx_n   = '0;
      sh_a_n  = in_a;
      sh_b_n  = in_b;
    end
    // flush wins over everything; accept is already blocked through in_ready
    if (flush) begin
      state_n = IDLE;
      idx_n   = '0;
      gap_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      a           <= 1'b0;
      b           <= 1'b0;
      carryin     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_idx     <= idx_n;
      gap_cnt     <= gap_n;
      sh_a        <= sh_a_n;
      sh_b        <= sh_b_n;
      a           <= (state_n == SHIFT) && sh_a_n[0];
      b           <= (state_n == SHIFT) && sh_b_n[0];
      bit_valid   <= (state_n == SHIFT);
      frame_start <= (state_n == SHIFT) && (idx_n == '0);
      frame_last  <= (state_n == SHIFT) && (idx_n == LAST_IDX);
      busy        <= (state_n != IDLE);
      if (accept) carryin <= in_cin;
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: a GAP=0 and a GAP=2 instance, each with a
// per-bit expected queue filled at accept and drained as bits appear.
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, in_valid = 1'b0, in_cin = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       in_ready, a, b, carryin, bit_valid, frame_start, frame_last, busy;
  logic [1:0] bit_idx;

  logic       g_flush = 1'b0, g_valid = 1'b0, g_cin = 1'b0;
  logic [3:0] g_a = '0, g_b = '0;
  logic       g_ready, g_sa, g_sb, g_carryin, g_bit_valid, g_fs, g_fl, g_busy;
  logic [1:0] g_idx;

  logic [7:0] obs, g_obs;
  assign obs   = {bit_valid, a, b, bit_idx, frame_start, frame_last, carryin};
  assign g_obs = {g_bit_valid, g_sa, g_sb, g_idx, g_fs, g_fl, g_carryin};

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] idx;
  } bit_t;

  bit_t q[$];
  bit_t gq[$];
  logic exp_cin = 1'b0;
  logic g_exp_cin = 1'b0;
  int   g_gap = 0;
  int   g_acc = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(4), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .a(a), .b(b), .carryin(carryin),
    .bit_valid(bit_valid), .bit_idx(bit_idx), .frame_start(frame_start),
    .frame_last(frame_last), .busy(busy)
  );

  serial_operand_feeder #(.WIDTH(4), .GAP(2)) dut_gap (
    .clk(clk), .rst_n(rst_n), .flush(g_flush), .in_valid(g_valid), .in_ready(g_ready),
    .in_a(g_a), .in_b(g_b), .in_cin(g_cin), .a(g_sa), .b(g_sb), .carryin(g_carryin),
    .bit_valid(g_bit_valid), .bit_idx(g_idx), .frame_start(g_fs),
    .frame_last(g_fl), .busy(g_busy)
  );

  function automatic logic [7:0] m_exp();
    if (q.size() == 0) return {7'b0, exp_cin};
    return {1'b1, q[0].a, q[0].b, q[0].idx, q[0].idx == 2'd0, q[0].idx == 2'd3, exp_cin};
  endfunction

  function automatic logic m_ready();
    return q.size() <= 1;
  endfunction

  function automatic logic [7:0] g_exp();
    if (gq.size() == 0) return {7'b0, g_exp_cin};
    return {1'b1, gq[0].a, gq[0].b, gq[0].idx, gq[0].idx == 2'd0, gq[0].idx == 2'd3, g_exp_cin};
  endfunction

  function automatic logic g_model_ready();
    return (gq.size() == 0) && (g_gap <= 1);
  endfunction

  // drive one cycle on the GAP=0 instance and advance its model past the next edge
  task automatic tick(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                      input logic c, input logic f);
    logic acc;
    in_valid = v; in_a = ta; in_b = tb_; in_cin = c; flush = f;
    acc = v && !f && m_ready();
    if (f) q.delete();
    else if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      for (int i = 0; i < 4; i++) q.push_back('{ta[i], tb_[i], 2'(i)});
      exp_cin = c;
    end
    @(negedge clk); #1;
  endtask

  task automatic gtick(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                       input logic c);
    logic acc;
    g_valid = v; g_a = ta; g_b = tb_; g_cin = c;
    acc = v && g_model_ready();
    if (gq.size() > 0) begin
      void'(gq.pop_front());
      if (gq.size() == 0) g_gap = 2;
    end else if (g_gap > 0) begin
      g_gap--;
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) gq.push_back('{ta[i], tb_[i], 2'(i)});
      g_exp_cin = c;
      g_acc++;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({obs, busy, in_ready} !== 10'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0", {obs, busy, in_ready});
    end
    n_cmp++;
    if ({g_obs, g_busy, g_ready} !== 10'b0) begin
      n_err++; $display("FAIL reset_outputs_gap: got %b want 0", {g_obs, g_busy, g_ready});
    end
    rst_n = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    tick(1'b1, 4'b1011, 4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== m_exp() || busy !== 1'b1 || in_ready !== m_ready()) begin
        n_err++; $display("FAIL single c%0d: got %b/%b/%b want %b/1/%b", i + 1,
                          obs, busy, in_ready, m_exp(), m_ready());
      end
      tick(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    end
    n_cmp++;
    if (obs !== m_exp() || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_idle: got %b/%b/%b want %b/0/1", obs, busy, in_ready, m_exp());
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 4'b0101, 4'b1100, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs !== m_exp() || bit_valid !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL b2b c%0d: got %b/%b want %b/1", i, obs, busy, m_exp());
      end
      n_cmp++;
      if (in_ready !== m_ready()) begin
        n_err++; $display("FAIL b2b_ready c%0d: got %b want %b", i, in_ready, m_ready());
      end
      tick(i < 4, 4'b1110, 4'b0011, 1'b1, 1'b0);
    end
    n_cmp++;
    if (obs !== m_exp() || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got %b/%b want %b/0", obs, busy, m_exp());
    end
  endtask

  task automatic test_gap();
    int first_v, last_v, n_v;
    first_v = -1; last_v = -1; n_v = 0;
    g_acc = 0;
    gtick(1'b1, 4'b1001, 4'b0111, 1'b1);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (g_obs !== g_exp() || g_busy !== ((gq.size() > 0) || (g_gap > 0)) ||
          g_ready !== g_model_ready()) begin
        n_err++; $display("FAIL gap c%0d: got %b/%b/%b want %b/%b/%b", i, g_obs, g_busy,
                          g_ready, g_exp(), (gq.size() > 0) || (g_gap > 0), g_model_ready());
      end
      if (g_bit_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_v++;
      end
      gtick(g_acc < 2, 4'b0110, 4'b1010, 1'b0);
    end
    n_cmp++;
    if (n_v !== 8 || (last_v - first_v + 1 - n_v) !== 2) begin
      n_err++; $display("FAIL gap_bubbles: got %0d valid, %0d idle want 8, 2",
                        n_v, last_v - first_v + 1 - n_v);
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 4'b0111, 4'b1101, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs !== m_exp()) begin
        n_err++; $display("FAIL flush_pre c%0d: got %b want %b", i, obs, m_exp());
      end
      if (i == 0) tick(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    end
    flush = 1'b1; in_valid = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_ready_block: got %b want 0", in_ready);
    end
    tick(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; #1;
    n_cmp++;
    if (obs !== m_exp() || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_post: got %b/%b/%b want %b/0/1", obs, busy, in_ready, m_exp());
    end
    tick(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== m_exp() || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_no_accept: got %b/%b want %b/0", obs, busy, m_exp());
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 4'b1010, 4'b0101, 1'b1, 1'b0);
    tick(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    tick(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== m_exp() || bit_idx !== 2'd2) begin
      n_err++; $display("FAIL rstmid_pre: got %b idx %0d want %b idx 2", obs, bit_idx, m_exp());
    end
    #2 rst_n = 1'b0; #1;
    q.delete(); gq.delete(); exp_cin = 1'b0; g_exp_cin = 1'b0; g_gap = 0;
    n_cmp++;
    if ({obs, busy, in_ready} !== 10'b0) begin
      n_err++; $display("FAIL rstmid_async: got %b want 0", {obs, busy, in_ready});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tick(1'b1, 4'b0011, 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== m_exp()) begin
        n_err++; $display("FAIL rstmid_post c%0d: got %b want %b", i, obs, m_exp());
      end
      tick(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ignored_inputs();
    tick(1'b1, 4'b1100, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== m_exp() || in_ready !== m_ready()) begin
        n_err++; $display("FAIL ignored c%0d: got %b/%b want %b/%b", i, obs, in_ready,
                          m_exp(), m_ready());
      end
      tick(i < 2, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    end
    n_cmp++;
    if (obs !== m_exp() || busy !== 1'b0) begin
      n_err++; $display("FAIL ignored_idle: got %b/%b want %b/0", obs, busy, m_exp());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_flush();
    test_reset_mid();
    test_ignored_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
